// File: rtl/alu_sub_pipe.sv
// Pipelined add/subtract ALU with valid/ready handshakes and a stored carry/borrow
// flag that lets multi-word add/sub chains issue back-to-back.
module alu_sub_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             use_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             zero,
  output logic             flag_q
);

  localparam int unsigned SUM_W = WIDTH + 1;

  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_ADC = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00011;
  localparam logic [4:0] OP_SBC = 5'b00100;
  localparam logic [4:0] OP_RSB = 5'b00101;
  localparam logic [4:0] OP_RSC = 5'b00110;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             zero;
  } stage_t;

  stage_t stg [STAGES];

  logic             adv;
  logic             accept;
  logic             ci;
  logic             legal;
  logic             is_sub;
  logic [WIDTH-1:0] opx;
  logic [WIDTH-1:0] opy;
  logic             opc;
  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] res_f;
  logic             res_cout;
  logic             res_zero;

  // Global stall: every stage moves together whenever the output slot can drain.
  assign adv      = !stg[STAGES-1].valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;
  assign ci       = use_flag ? flag_q : cin;

  // Operand selection; subtraction is done as x + ~y + carry.
  always_comb begin
    opx    = '0;
    opy    = '0;
    opc    = 1'b0;
    legal  = 1'b1;
    is_sub = 1'b0;
    unique case (op)
      OP_ADD: begin opx = a; opy = b; opc = 1'b0; end
      OP_ADC: begin opx = a; opy = b; opc = ci; end
      OP_SUB: begin opx = a; opy = ~b; opc = 1'b1; is_sub = 1'b1; end
      OP_SBC: begin opx = a; opy = ~b; opc = !ci; is_sub = 1'b1; end
      OP_RSB: begin opx = b; opy = ~a; opc = 1'b1; is_sub = 1'b1; end
      OP_RSC: begin opx = b; opy = ~a; opc = !ci; is_sub = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    sum      = SUM_W'(opx) + SUM_W'(opy) + SUM_W'(opc);
    res_f    = legal ? sum[WIDTH-1:0] : '0;
    res_cout = legal ? sum[WIDTH] : 1'b0;
    res_zero = (res_f == '0);
  end

  // Stage 1 captures the arithmetic; later stages are plain delay registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) stg[i] <= '0;
    end else if (adv) begin
      stg[0] <= '{valid: accept, f: res_f, cout: res_cout, zero: res_zero};
      for (int unsigned i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  // Chain flag: carry for add-type ops, borrow for subtract-type ops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
    end else if (accept && legal) begin
      flag_q <= is_sub ? !res_cout : res_cout;
    end
  end

  assign out_valid = stg[STAGES-1].valid;
  assign f         = stg[STAGES-1].f;
  assign cout      = stg[STAGES-1].cout;
  assign zero      = stg[STAGES-1].zero;

endmodule

// File: tb/tb_alu_sub_pipe.sv
// Scoreboard bench for alu_sub_pipe (WIDTH=32, STAGES=2): a driver pushes
// hand-computed results on each accept, a monitor pops and compares on each drain.
module tb_alu_sub_pipe;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 2;
  localparam int          BOUND  = 20;

  typedef struct packed {
    logic [WIDTH-1:0] f;
    logic             cout;
    logic             zero;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             use_flag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             zero;
  logic             flag_q;

  exp_t sb [$];
  int   total = 0;
  int   bad   = 0;

  alu_sub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .use_flag(use_flag),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .cout(cout),
    .zero(zero), .flag_q(flag_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare every drained result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got f=0x%0h expected no result", f);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_f", 64'(f), 64'(e.f));
        chk("result_cout", 64'(cout), 64'(e.cout));
        chk("result_zero", 64'(zero), 64'(e.zero));
      end
    end
  end

  // Offer one op until accepted; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [4:0] o, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                       input logic xc, input logic xu,
                       input logic [WIDTH-1:0] ef, input logic ec, input logic ez);
    in_valid = 1'b1; op = o; a = xa; b = xb; cin = xc; use_flag = xu;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{f: ef, cout: ec, zero: ez});
        break;
      end
      if (n >= BOUND) begin
        chk("accept_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0; use_flag = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < BOUND && sb.size() != 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_flag", 64'(flag_q), 64'd0);
    chk("rst_f", 64'(f), 64'd0);
    chk("rst_cout_zero", {62'd0, cout, zero}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    // SUB 5-3 with latency check
    issue(5'b00011, 32'd5, 32'd3, 1'b0, 1'b0, 32'd2, 1'b1, 1'b0);
    idle();
    chk("sub_flag", 64'(flag_q), 64'd0);
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_two", 64'(out_valid), 64'd1);
    drain();

    // 64-bit chain: (1:0) - (0:1)
    issue(5'b00011, 32'd0, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("chain_lo_flag", 64'(flag_q), 64'd1);
    issue(5'b00100, 32'd1, 32'd0, 1'b0, 1'b1, 32'd0, 1'b1, 1'b1);
    idle();
    chk("chain_hi_flag", 64'(flag_q), 64'd0);

    // Reverse subtracts
    issue(5'b00101, 32'd7, 32'd7, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("rsb_flag", 64'(flag_q), 64'd0);
    issue(5'b00110, 32'd0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("rsc_flag", 64'(flag_q), 64'd1);

    // Illegal op leaves flag alone
    issue(5'b11111, 32'd9, 32'd4, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("illegal_flag", 64'(flag_q), 64'd1);

    // Add chain: carry out then ADC consumes it; ADC with explicit cin
    issue(5'b00001, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    chk("add_carry_flag", 64'(flag_q), 64'd1);
    issue(5'b00010, 32'd2, 32'd3, 1'b0, 1'b1, 32'd6, 1'b0, 1'b0);
    chk("adc_flag", 64'(flag_q), 64'd0);
    issue(5'b00010, 32'd10, 32'd20, 1'b1, 1'b0, 32'd31, 1'b0, 1'b0);
    idle();
    drain();

    // Stall with a full pipeline
    out_ready = 1'b0;
    issue(5'b00001, 32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0);
    issue(5'b00001, 32'd2, 32'd2, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0);
    fork
      issue(5'b00001, 32'd3, 32'd3, 1'b0, 1'b0, 32'd6, 1'b0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          chk("stall_f", 64'(f), 64'd2);
          chk("stall_flag", 64'(flag_q), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    idle();
    chk("stream_v4", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    chk("stream_v6", 64'(out_valid), 64'd1);
    drain();

    // Reset with two ops in flight
    out_ready = 1'b0;
    issue(5'b00001, 32'd5, 32'd5, 1'b0, 1'b0, 32'd10, 1'b0, 1'b0);
    issue(5'b00011, 32'd5, 32'd6, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle();
    chk("pre_rst_flag", 64'(flag_q), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_flag", 64'(flag_q), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    begin
      int seen;
      seen = 0;
      repeat (5) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("no_stale_result", 64'(seen), 64'd0);
    end

    // Back-to-back throughput after reset
    issue(5'b00001, 32'd100, 32'd23, 1'b0, 1'b0, 32'd123, 1'b0, 1'b0);
    issue(5'b00011, 32'd3, 32'd5, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
